// File: rtl/nonce_header_feeder_if.sv
// Bundle between the miner controller, the SHA block and the nonce header feeder.
// Purely wiring: no latency of its own.
// No backpressure: the feeder sequences the SHA block with begin/complete pulses.
interface nonce_header_feeder_if #(
    parameter int HDR_WORDS = 19,
    parameter int WORD_W    = 32
);
    logic                              load_msg;
    logic                              clear;
    logic                              increment;
    logic [HDR_WORDS*WORD_W-1:0]       header_in;
    logic [WORD_W-1:0]                 start_nonce;
    logic                              computation_complete;
    logic [(HDR_WORDS+1)*WORD_W-1:0]   msg_out;
    logic                              begin_computation;
    logic [WORD_W-1:0]                 current_nonce;
    logic                              result_ready;
    logic [WORD_W-1:0]                 result_nonce;
    logic                              overflow;
    logic                              busy;

    // Controller / SHA side: drives commands and completion, observes the feeder.
    modport master (
        output load_msg, clear, increment, header_in, start_nonce, computation_complete,
        input  msg_out, begin_computation, current_nonce, result_ready, result_nonce,
               overflow, busy
    );

    // Feeder side.
    modport slave (
        input  load_msg, clear, increment, header_in, start_nonce, computation_complete,
        output msg_out, begin_computation, current_nonce, result_ready, result_nonce,
               overflow, busy
    );
endinterface

// File: rtl/nonce_header_feeder.sv
// Purpose: hold the block header, append the nonce, and sequence one SHA hash per nonce.
// Latency: begin_computation one cycle after load/increment; result_ready one cycle after complete.
// Backpressure: none; waits in BUSY for complete and in HOLD for increment. Optional
// feature macro NONCE_BYTE_SWAP_EN byte-reverses the nonce word placed in msg_out.
module nonce_header_feeder #(
    parameter int HDR_WORDS = 19,
    parameter int WORD_W    = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    nonce_header_feeder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        BUSY   = 3'd2,
        REPORT = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t                        state;
    state_t                        nextState;

    logic [HDR_WORDS*WORD_W-1:0]   headerReg;
    logic [WORD_W-1:0]             nonceReg;
    logic [WORD_W-1:0]             resultNonce;
    logic                          ovfReg;
    logic [WORD_W-1:0]             nonceWord;

    logic                          captureEn;
    logic                          stepNonce;
    logic                          latchResult;
    logic                          setOvf;
    logic                          clrOvf;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and datapath strobes; clear beats load_msg beats increment.
    always_comb begin
        nextState   = state;
        captureEn   = 1'b0;
        stepNonce   = 1'b0;
        latchResult = 1'b0;
        setOvf      = 1'b0;
        clrOvf      = 1'b0;
        if (bus.clear) begin
            nextState = IDLE;
            clrOvf    = 1'b1;
        end else if (bus.load_msg) begin
            // Also the abort path: a stale complete then lands in ISSUE and is dropped.
            nextState = ISSUE;
            captureEn = 1'b1;
            clrOvf    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    nextState = IDLE;
                end
                ISSUE: begin
                    nextState = BUSY;
                end
                BUSY: begin
                    if (bus.computation_complete) begin
                        latchResult = 1'b1;
                        nextState   = REPORT;
                    end
                end
                REPORT, HOLD: begin
                    if (bus.increment) begin
                        if (&nonceReg) begin
                            // Last nonce already hashed: flag exhaustion, keep the nonce.
                            setOvf    = 1'b1;
                            nextState = IDLE;
                        end else begin
                            stepNonce = 1'b1;
                            nextState = ISSUE;
                        end
                    end else begin
                        nextState = HOLD;
                    end
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // Header, nonce, result and overflow registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            headerReg   <= '0;
            nonceReg    <= '0;
            resultNonce <= '0;
            ovfReg      <= 1'b0;
        end else begin
            if (captureEn) begin
                headerReg <= bus.header_in;
                nonceReg  <= bus.start_nonce;
            end else if (stepNonce) begin
                nonceReg <= nonceReg + WORD_W'(1);
            end
            if (latchResult) begin
                resultNonce <= nonceReg;
            end
            if (clrOvf) begin
                ovfReg <= 1'b0;
            end else if (setOvf) begin
                ovfReg <= 1'b1;
            end
        end
    end

`ifdef NONCE_BYTE_SWAP_EN
    // Little-endian header encoding: byte-reverse the nonce word only in the message.
    always_comb begin
        nonceWord = nonceReg;
        for (int b = 0; b < WORD_W / 8; b++) begin
            nonceWord[b*8 +: 8] = nonceReg[WORD_W-8-b*8 +: 8];
        end
    end
`else
    assign nonceWord = nonceReg;
`endif

    assign bus.msg_out           = {nonceWord, headerReg};
    assign bus.current_nonce     = nonceReg;
    assign bus.result_nonce      = resultNonce;
    assign bus.overflow          = ovfReg;
    assign bus.begin_computation = (state == ISSUE);
    assign bus.result_ready      = (state == REPORT);
    assign bus.busy              = (state != IDLE);

endmodule

// File: tb/tb_nonce_header_feeder.sv
// Directed bench for nonce_header_feeder: load/complete, increment loop, wrap, abort,
// priority, async reset and the nonce word placement (swapped when NONCE_BYTE_SWAP_EN).
// Inputs change 1 ns after the rising edge; outputs are read there too.
module tb_nonce_header_feeder;

    localparam int HDR_WORDS = 19;
    localparam int WORD_W    = 32;

    logic clk;
    logic n_rst;
    int   checkCnt;
    int   failCnt;
    int   beginCnt;
    int   beginMark;

    nonce_header_feeder_if #(.HDR_WORDS(HDR_WORDS), .WORD_W(WORD_W)) bus ();

    nonce_header_feeder #(.HDR_WORDS(HDR_WORDS), .WORD_W(WORD_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count begin pulses mid-cycle, well away from the edge where they change.
    always @(negedge clk) begin
        if (bus.begin_computation === 1'b1) beginCnt++;
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRun(input logic [31:0] nonce);
        bus.start_nonce = nonce;
        bus.load_msg    = 1'b1;
        step();
        bus.load_msg    = 1'b0;
    endtask

    // Pulse complete while in BUSY and check the report cycle, then move on to HOLD.
    task automatic completeRun(input string tag, input logic [31:0] expNonce);
        bus.computation_complete = 1'b1;
        step();
        bus.computation_complete = 1'b0;
        checkVal({tag, "_rdy"}, 64'(bus.result_ready), 64'd1);
        checkVal({tag, "_rnonce"}, 64'(bus.result_nonce), 64'(expNonce));
    endtask

    function automatic logic [31:0] expNonceWord(input logic [31:0] n);
`ifdef NONCE_BYTE_SWAP_EN
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
        return n;
`endif
    endfunction

    initial begin
        checkCnt = 0;
        failCnt  = 0;
        beginCnt = 0;
        n_rst    = 1'b0;
        bus.load_msg             = 1'b0;
        bus.clear                = 1'b0;
        bus.increment            = 1'b0;
        bus.computation_complete = 1'b0;
        bus.start_nonce          = '0;
        for (int i = 0; i < HDR_WORDS; i++) bus.header_in[i*32 +: 32] = 32'(i);

        // Reset state.
        #3;
        checkVal("rst_msg_zero", 64'(bus.msg_out == '0), 64'd1);
        checkVal("rst_busy", 64'(bus.busy), 64'd0);
        checkVal("rst_begin", 64'(bus.begin_computation), 64'd0);
        checkVal("rst_ovf", 64'(bus.overflow), 64'd0);
        step();
        n_rst = 1'b1;
        step();

        // Load and complete after 5 cycles.
        beginMark = beginCnt;
        loadRun(32'h10);
        checkVal("load_begin", 64'(bus.begin_computation), 64'd1);
        checkVal("load_nonce_word", 64'(bus.msg_out[19*32 +: 32]), 64'(expNonceWord(32'h10)));
        checkVal("load_hdr_w5", 64'(bus.msg_out[5*32 +: 32]), 64'd5);
        checkVal("load_hdr_w18", 64'(bus.msg_out[18*32 +: 32]), 64'd18);
        checkVal("load_cur", 64'(bus.current_nonce), 64'h10);
        step();
        checkVal("busy_begin_low", 64'(bus.begin_computation), 64'd0);
        step(); step(); step();
        completeRun("first", 32'h10);
        step();
        checkVal("hold_rdy_low", 64'(bus.result_ready), 64'd0);
        checkVal("first_begins", 64'(beginCnt - beginMark), 64'd1);

        // Increment loop, incremented from HOLD.
        beginMark = beginCnt;
        for (int k = 1; k <= 3; k++) begin
            bus.increment = 1'b1;
            step();
            bus.increment = 1'b0;
            checkVal("inc_begin", 64'(bus.begin_computation), 64'd1);
            checkVal("inc_cur", 64'(bus.current_nonce), 64'(32'h10 + k));
            step(); step();
            completeRun("inc", 32'h10 + 32'(k));
            step();
        end
        checkVal("inc_begins", 64'(beginCnt - beginMark), 64'd3);

        // Wrap: first increment taken in REPORT, second overflows.
        loadRun(32'hFFFF_FFFE);
        step();
        completeRun("wrap0", 32'hFFFF_FFFE);
        bus.increment = 1'b1;
        step();
        bus.increment = 1'b0;
        checkVal("wrap_report_inc", 64'(bus.current_nonce), 64'hFFFF_FFFF);
        checkVal("wrap_report_begin", 64'(bus.begin_computation), 64'd1);
        step();
        completeRun("wrap1", 32'hFFFF_FFFF);
        step();
        beginMark = beginCnt;
        bus.increment = 1'b1;
        step();
        bus.increment = 1'b0;
        checkVal("ovf_set", 64'(bus.overflow), 64'd1);
        checkVal("ovf_idle", 64'(bus.busy), 64'd0);
        checkVal("ovf_cur", 64'(bus.current_nonce), 64'hFFFF_FFFF);
        step(); step();
        checkVal("ovf_no_begin", 64'(beginCnt - beginMark), 64'd0);
        checkVal("ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        checkVal("clear_ovf", 64'(bus.overflow), 64'd0);

        // Abort mid-run; stale complete lands in the new ISSUE cycle.
        beginMark = beginCnt;
        loadRun(32'h50);
        step();
        loadRun(32'h100);
        checkVal("abort_issue", 64'(bus.begin_computation), 64'd1);
        bus.computation_complete = 1'b1;
        step();
        bus.computation_complete = 1'b0;
        checkVal("stale_rdy", 64'(bus.result_ready), 64'd0);
        checkVal("stale_rnonce", 64'(bus.result_nonce), 64'hFFFF_FFFF);
        step();
        completeRun("abort", 32'h100);
        step();
        checkVal("abort_begins", 64'(beginCnt - beginMark), 64'd2);

        // Priority clear over load_msg, then spurious complete in IDLE.
        beginMark = beginCnt;
        bus.clear    = 1'b1;
        bus.load_msg = 1'b1;
        bus.start_nonce = 32'h999;
        step();
        bus.clear    = 1'b0;
        bus.load_msg = 1'b0;
        checkVal("prio_idle", 64'(bus.busy), 64'd0);
        checkVal("prio_cur_kept", 64'(bus.current_nonce), 64'h100);
        bus.computation_complete = 1'b1;
        step();
        bus.computation_complete = 1'b0;
        checkVal("spur_rdy", 64'(bus.result_ready), 64'd0);
        step();
        checkVal("spur_rdy2", 64'(bus.result_ready), 64'd0);
        checkVal("prio_no_begin", 64'(beginCnt - beginMark), 64'd0);

        // Asynchronous reset mid-BUSY.
        loadRun(32'h77);
        step();
        beginMark = beginCnt;
        n_rst = 1'b0;
        #1;
        checkVal("arst_msg", 64'(bus.msg_out == '0), 64'd1);
        checkVal("arst_busy", 64'(bus.busy), 64'd0);
        checkVal("arst_cur", 64'(bus.current_nonce), 64'd0);
        checkVal("arst_rnonce", 64'(bus.result_nonce), 64'd0);
        bus.computation_complete = 1'b1;
        step();
        bus.computation_complete = 1'b0;
        n_rst = 1'b1;
        step(); step();
        checkVal("arst_no_rdy", 64'(bus.result_ready), 64'd0);
        checkVal("arst_no_begin", 64'(beginCnt - beginMark), 64'd0);

        // Nonce word placement.
        loadRun(32'h1234_5678);
        checkVal("swap_word", 64'(bus.msg_out[19*32 +: 32]), 64'(expNonceWord(32'h1234_5678)));
        checkVal("swap_cur", 64'(bus.current_nonce), 64'h1234_5678);
        step();
        completeRun("swap", 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/nonce_header_feeder.md
# nonce_header_feeder

Holds the 19-word block header captured from the slave register file, appends the 32-bit nonce, and drives the assembled 640-bit message into the SHA computational block. It issues the begin pulse, waits for completion, reports which nonce the result belongs to, and steps the nonce when the controller requests an increment. Nonce exhaustion is flagged as overflow. It sits directly upstream of the SHA block and is sequenced by the miner controller.

## Interface
- HDR_WORDS, 19: header words excluding the nonce.
- WORD_W, 32: word width; also the nonce width.
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- load_msg  input  1  capture header_in and start_nonce, then start a run
- clear  input  1  abort to IDLE and clear overflow
- increment  input  1  step to the next nonce and reissue
- header_in  input  HDR_WORDS*WORD_W  header words, word 0 in the LSBs
- start_nonce  input  WORD_W  first nonce of a run
- computation_complete  input  1  SHA block finished (single-cycle pulse)
- msg_out  output  (HDR_WORDS+1)*WORD_W  header words 0..18, nonce word in the MSBs
- begin_computation  output  1  one-cycle start pulse to the SHA block
- current_nonce  output  WORD_W  nonce currently in msg_out
- result_ready  output  1  one-cycle pulse: the SHA output corresponds to result_nonce
- result_nonce  output  WORD_W  nonce of the most recent completed hash
- overflow  output  1  sticky flag: nonce space exhausted
- busy  output  1  high in ISSUE, BUSY, REPORT and HOLD

## Operation
- States: IDLE, ISSUE, BUSY, REPORT, HOLD.
- **IDLE**
  - load_msg: register header_in and start_nonce; overflow is cleared; go to ISSUE.
  - Other inputs are ignored.
- **ISSUE**
  - begin_computation = 1 for exactly this cycle; go to BUSY.
- **BUSY**
  - Wait for computation_complete.
  - On computation_complete: result_nonce <= nonce; go to REPORT.
- **REPORT**
  - result_ready = 1 for exactly this cycle; go to HOLD.
  - An increment seen in REPORT is handled exactly as in HOLD.
- **HOLD**
  - Wait for increment.
  - If nonce == 2^WORD_W−1: set overflow; nonce is unchanged; go to IDLE.
  - Otherwise: nonce <= nonce+1, modulo 2^WORD_W with no carry out; go to ISSUE.
- **clear**
  - In any state: go to IDLE next cycle.
  - overflow <= 0.
  - Header, nonce and result_nonce are retained.
- **load_msg outside IDLE**
  - Aborts the current run: recapture, then go to ISSUE.
  - A later computation_complete from the aborted hash is dropped, because it arrives in ISSUE rather than BUSY.
- **Priority:** clear > load_msg > increment.
- **computation_complete outside BUSY** is ignored.
- **msg_out and current_nonce** are stable from ISSUE until the next state change out of HOLD/REPORT. The SHA block may sample them at any point while busy.
- **overflow** stays set until load_msg or clear.

## Timing
- **Reset values (all outputs):**
  - state IDLE; msg_out 0; current_nonce 0; result_nonce 0.
  - begin_computation 0; result_ready 0; overflow 0; busy 0.
- **Outputs are registered or Moore-decoded.** There is no combinational input-to-output path.
- **load_msg sampled at edge k:**
  - msg_out is valid after edge k.
  - begin_computation is high in cycle k+1.
- **computation_complete sampled at edge j:**
  - result_ready and result_nonce are valid in cycle j+1.
- **increment sampled at edge m (non-wrap):**
  - New nonce after edge m.
  - begin_computation in cycle m+1.
- **Per-nonce overhead excluding the SHA latency:** 3 cycles (ISSUE, REPORT, and the increment cycle in HOLD), or 2 cycles if increment arrives in REPORT.
- **Asynchronous reset mid-run:** every register returns to its reset value immediately; no begin or result pulse is emitted afterward.

## Configuration
- **Macro:** NONCE_BYTE_SWAP_EN.
- **Defined:** the nonce word in msg_out is byte-reversed (little-endian header encoding), i.e. {n[7:0],n[15:8],n[23:16],n[31:24]}.
- **Not defined:** the nonce word is placed as-is.
- **Unaffected either way:** current_nonce and result_nonce are always the un-swapped counter value.

## Test plan
- **Load and complete:** load_msg with start_nonce=0x00000010 and header word i=i, then complete after 5 cycles.
  - begin_computation pulses once, the cycle after load.
  - msg_out nonce word = 0x00000010.
  - result_ready carries result_nonce=0x00000010.
- **Increment loop:** three increments, each answered by a complete.
  - Nonces 0x11, 0x12, 0x13 are issued.
  - Exactly one begin per nonce; result_nonce tracks each nonce.
- **Wrap and clear:** start_nonce=0xFFFFFFFE, complete and increment twice.
  - Second increment: overflow=1, state IDLE, no further begin, current_nonce=0xFFFFFFFF.
  - clear then drops overflow to 0.
- **Abort mid-run:** load_msg in BUSY with start_nonce=0x100; the stale complete lands in the ISSUE cycle.
  - The stale complete is ignored.
  - A fresh begin is issued; the next result_nonce=0x100.
- **Priority and spurious complete:** clear and load_msg asserted in the same cycle; also computation_complete pulsed in IDLE.
  - clear wins: state IDLE, no begin.
  - The spurious complete produces no result_ready.
- **Reset and byte swap:** n_rst asserted mid-BUSY, then the NONCE_BYTE_SWAP_EN build.
  - During reset: all outputs 0 immediately.
  - With the macro and nonce 0x12345678: msg_out nonce word = 0x78563412 while current_nonce = 0x12345678.
